aes_stream_ctrl: RTL and testbench
==================================

# aes_stream_ctrl

Byte-stream front end for the AES-128 core. Collects 16 input bytes into a 128-bit block, launches the core with a one-cycle start pulse, waits for its done flag, then returns the 16 result bytes on a ready/valid output stream. It acts as the initiator on the core's start/done/data/key interface, replacing bench-level sequencing in the real datapath.

## Interface
- TIMEOUT, 200: maximum cycles to wait for `i_AesDone` after the start pulse. Active only with the timeout watchdog compiled in.
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-low reset.
- i_Valid  input  1  input byte valid.
- i_Byte  input  8  input byte; the first byte of a block maps to bits [127:120].
- o_Ready  output  1  input byte accepted when `i_Valid && o_Ready`.
- i_fDec  input  1  mode: 0 = encrypt, 1 = decrypt. Sampled with the 16th input byte.
- i_Key  input  128  key. Sampled with the 16th input byte.
- o_AesStart  output  1  one-cycle start pulse to the core.
- o_AesDec  output  1  mode to the core.
- o_AesData  output  128  block to the core.
- o_AesKey  output  128  key to the core.
- i_AesData  input  128  core result.
- i_AesDone  input  1  core done flag.
- o_Valid  output  1  output byte valid.
- o_Byte  output  8  output byte, MSB byte first.
- i_Ready  input  1  downstream ready.
- o_Busy  output  1  high in every state except LOAD.
- o_Err  output  1  sticky timeout error.

## Operation
States:
- **LOAD**
  - `o_Ready=1`.
  - Each accepted byte shifts into the block register from the LSB end; the byte counter increments.
  - On the 16th accept, the register holds the block, `i_fDec` and `i_Key` are latched, and the state moves to START.
- **START**
  - `o_AesStart=1` for exactly one cycle.
  - `o_AesData`, `o_AesKey` and `o_AesDec` are stable from this cycle until the core's done is seen.
  - Next state: WAIT.
- **WAIT**
  - On `i_AesDone=1`, `i_AesData` is captured into the block register and the state moves to UNLOAD.
  - The watchdog counter runs in this state.
- **UNLOAD**
  - `o_Valid=1` and `o_Byte` = register[127:120].
  - On `o_Valid && i_Ready`, the register shifts left by 8 and the counter increments.
  - After the 16th transfer, the state returns to LOAD with the counter at 0.
- **ERR**
  - Entered when the watchdog expires.
  - `o_Err=1`, `o_Ready=0`, `o_Valid=0`.
  - Left only by reset.

Rules:
- The byte counter is 4 bits and wraps from 15 to 0 at the end of each phase.
- One 128-bit register serves load, AES operand and unload; the phases never overlap.
- `i_AesDone` outside WAIT is ignored.
- `i_Valid` outside LOAD is not accepted; the byte must be held by the source.

## Timing
- **Reset values:** all outputs 0; state LOAD; counters 0; register 0. `o_Ready` rises on the first clock edge after `Rst` deasserts.
- **Reset mid-operation:**
  - The partial block and any pending output are discarded.
  - Any `o_AesStart` in flight is dropped.
  - An outstanding core operation is abandoned, and a late done is ignored.
- **Launch latency:** 16th byte accepted at edge N → `o_AesStart` high during cycle N+1 → WAIT from edge N+2.
- **Result latency:** `i_AesDone` sampled at edge M → first `o_Valid` during cycle M+1.
- **Back-to-back throughput:** one byte per cycle on both streams. One idle `o_Ready` cycle (START) plus the core latency separates the input phase from the output phase.
- **Output stability:** `o_Byte` holds while `o_Valid && !i_Ready`.
- **Timeout and done in the same cycle:** done wins.
- **Timeout boundary:** the watchdog expires when TIMEOUT cycles have elapsed in WAIT without done.

## Configuration
- `AES_STREAM_TIMEOUT_EN` defined:
  - The watchdog counter (width `$clog2(TIMEOUT+1)`) and the ERR state exist.
  - `o_Err` behaves as above.
- Not defined:
  - No counter and no ERR state.
  - WAIT lasts indefinitely until done.
  - `o_Err` is tied to 0 and TIMEOUT is unused.

## Structure
- Package `aes_stream_pkg` holds:
  - the state encoding (LOAD, START, WAIT, UNLOAD, ERR);
  - `AES_BLOCK_BYTES=16`;
  - `AES_BYTE_CNT_W=4`.
- Sub-module `aes_byte_shifter`:
  - 128-bit register with parallel load, shift-in byte at the LSB end, shift-left-by-8 and MSB byte output;
  - shared by the load and unload phases.
- Top: FSM, counters, mode/key latch, watchdog.

## Test plan
1. **Encrypt:** key 5468617473206D79204B756E67204675, input bytes 54 77 6F 20 4F 6E 65 20 4E 69 6E 65 20 54 77 6F, `i_fDec=0` → one `o_AesStart` pulse with `o_AesData`=54776F204F6E65204E696E652054776F and `o_AesDec=0`; output bytes 29 C3 50 5F 57 14 20 F6 40 22 99 B3 1A 02 D7 3A.
2. **Decrypt:** same key, input bytes 29 C3 … 3A, `i_fDec=1` → `o_AesDec=1`; output bytes 54 77 6F … 77 6F.
3. **Backpressure:** `i_Ready=0` for 5 cycles after the first output byte → `o_Byte` holds 29 with `o_Valid` high; all 16 bytes are delivered in order with none lost or duplicated.
4. **Gapped input and blocked phases:**
   - `i_Valid` alternating 1/0 gives the same block as scenario 1.
   - Bytes offered during WAIT/UNLOAD are not accepted (`o_Ready=0`).
5. **Timeout (macro defined):** TIMEOUT=20 with a stub core that never asserts done → `o_Err` rises 20 cycles after WAIT entry and stays high; `o_Ready=0` until reset. With the macro undefined, `o_Err` stays 0.
6. **Reset mid-load:** `Rst` pulsed low after 7 accepted bytes → outputs return to 0; the next 16 bytes form the block exactly as in scenario 1.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: state encoding and block sizing shared by the AES byte-stream front end.
package aes_stream_pkg;
    typedef enum logic [2:0] {LOAD, START, WAIT, UNLOAD, ERR} state_t;
    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BYTE_CNT_W  = 4;
endpackage

// File: rtl/aes_byte_shifter.sv
// aes_byte_shifter: 128-bit block register with parallel load, LSB byte shift-in and MSB byte shift-out.
module aes_byte_shifter (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         load,
    input  logic [127:0] load_data,
    input  logic         shift_in,
    input  logic [7:0]   in_byte,
    input  logic         shift_out,
    output logic [127:0] data,
    output logic [7:0]   msb_byte
);
    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) data <= '0;
        else if (load) data <= load_data;
        else if (shift_in) data <= {data[119:0], in_byte};
        else if (shift_out) data <= {data[119:0], 8'h00};
    assign msb_byte = data[127:120];
endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: loads 16 bytes, runs the AES core once, streams 16 result bytes back out.
// Watchdog and ERR state are compiled in only with AES_STREAM_TIMEOUT_EN.
module aes_stream_ctrl
    import aes_stream_pkg::*;
#(
    parameter int TIMEOUT = 200
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         i_Valid,
    input  logic [7:0]   i_Byte,
    output logic         o_Ready,
    input  logic         i_fDec,
    input  logic [127:0] i_Key,
    output logic         o_AesStart,
    output logic         o_AesDec,
    output logic [127:0] o_AesData,
    output logic [127:0] o_AesKey,
    input  logic [127:0] i_AesData,
    input  logic         i_AesDone,
    output logic         o_Valid,
    output logic [7:0]   o_Byte,
    input  logic         i_Ready,
    output logic         o_Busy,
    output logic         o_Err
);
    state_t state, state_nx;
    logic [AES_BYTE_CNT_W-1:0] cnt;
    logic [127:0] key_q;
    logic live, dec_q, accept, xfer, last, wd_exp;
    assign accept = i_Valid && o_Ready;
    assign xfer   = o_Valid && i_Ready;
    assign last   = cnt == AES_BYTE_CNT_W'(AES_BLOCK_BYTES - 1);
`ifdef AES_STREAM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd;
    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) wd <= '0;
        else wd <= (state == WAIT) ? wd + 1'b1 : '0;
    assign wd_exp = wd == WD_W'(TIMEOUT - 1);
    assign o_Err  = state == ERR;
`else
    assign wd_exp = 1'b0;
    assign o_Err  = 1'b0;
`endif
    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) state <= LOAD;
        else state <= state_nx;
    // Done is checked before the watchdog so a same-cycle done always wins.
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (accept && last) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (i_AesDone) state_nx = UNLOAD;
                     else if (wd_exp) state_nx = ERR;
            UNLOAD:  if (xfer && last) state_nx = LOAD;
            default: state_nx = state;
        endcase
    end
    // live keeps o_Ready low until the first edge after reset release.
    always_comb begin
        o_Ready    = live && state == LOAD;
        o_Valid    = state == UNLOAD;
        o_AesStart = state == START;
        o_Busy     = state != LOAD;
    end
    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) begin
            live  <= 1'b0;
            cnt   <= '0;
            dec_q <= 1'b0;
            key_q <= '0;
        end else begin
            live <= 1'b1;
            if (accept || xfer) cnt <= cnt + 1'b1;
            if (accept && last) begin
                dec_q <= i_fDec;
                key_q <= i_Key;
            end
        end
    aes_byte_shifter u_shifter (
        .Clk       (Clk),
        .Rst       (Rst),
        .load      (state == WAIT && i_AesDone),
        .load_data (i_AesData),
        .shift_in  (accept),
        .in_byte   (i_Byte),
        .shift_out (xfer),
        .data      (o_AesData),
        .msb_byte  (o_Byte)
    );
    assign o_AesKey = key_q;
    assign o_AesDec = dec_q;
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: randomized bench with a stub AES core and a block-level reference model.
`timescale 1ns/1ps
module tb_aes_stream_ctrl;
    localparam int TO = 20;
    localparam logic [127:0] K  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] PT = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] CT = 128'h29C3505F571420F6402299B31A02D73A;

    logic Clk = 0, Rst = 0;
    logic i_Valid = 0, i_fDec = 0, i_AesDone = 0, i_Ready = 0;
    logic [7:0] i_Byte = 0;
    logic [127:0] i_Key = 0, i_AesData = 0;
    logic o_Ready, o_AesStart, o_AesDec, o_Valid, o_Busy, o_Err;
    logic [127:0] o_AesData, o_AesKey;
    logic [7:0] o_Byte;

    aes_stream_ctrl #(.TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst), .i_Valid(i_Valid), .i_Byte(i_Byte), .o_Ready(o_Ready),
        .i_fDec(i_fDec), .i_Key(i_Key), .o_AesStart(o_AesStart), .o_AesDec(o_AesDec),
        .o_AesData(o_AesData), .o_AesKey(o_AesKey), .i_AesData(i_AesData), .i_AesDone(i_AesDone),
        .o_Valid(o_Valid), .o_Byte(o_Byte), .i_Ready(i_Ready), .o_Busy(o_Busy), .o_Err(o_Err)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0, n_fail = 0;
    int core_lat = 2, n_start = 0, cnt_left = 0;
    bit core_en = 1, inject = 0, pending = 0, prev_start = 0, prev_done = 0;
    logic [127:0] st_data = 0, st_key = 0;
    logic st_dec = 0;

    // Stand-in for the AES core: the known vector pair, otherwise a keyed mixing function.
    function automatic logic [127:0] core_fn(input logic [127:0] d, k, input logic dec);
        if (k == K && !dec && d == PT) return CT;
        if (k == K && dec && d == CT) return PT;
        return d ^ {k[63:0], k[127:64]} ^ {16{dec ? 8'h5A : 8'hC3}};
    endfunction

    initial forever begin
        @(negedge Clk);
        if (prev_done) begin
            n_chk++;
            if (o_Valid !== 1'b1) begin n_fail++; $display("FAIL result_latency: o_Valid=%b required 1", o_Valid); end
        end
        if (pending && Rst) begin
            n_chk++;
            if ({o_AesData, o_AesKey, o_AesDec} !== {st_data, st_key, st_dec}) begin
                n_fail++; $display("FAIL operand_stable: data=%h key=%h dec=%b required %h %h %b", o_AesData, o_AesKey, o_AesDec, st_data, st_key, st_dec);
            end
        end
        if (prev_start && Rst) begin
            n_chk++;
            if (o_AesStart !== 1'b0) begin n_fail++; $display("FAIL start_pulse: o_AesStart=%b required 0", o_AesStart); end
        end
        prev_done = 0;
        i_AesDone = 0;
        if (!Rst) pending = 0;
        else if (inject) begin
            i_AesDone = 1; i_AesData = {4{$urandom}}; inject = 0;
        end else if (pending && core_en) begin
            if (cnt_left == 0) begin
                i_AesDone = 1; i_AesData = core_fn(st_data, st_key, st_dec); pending = 0; prev_done = 1;
            end else cnt_left--;
        end
        prev_start = o_AesStart === 1'b1;
        if (o_AesStart === 1'b1 && Rst) begin
            pending = 1; cnt_left = core_lat; n_start++;
            st_data = o_AesData; st_key = o_AesKey; st_dec = o_AesDec;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic offer_junk(input bit junk);
        if (junk) begin
            i_Valid = 1; i_Byte = 8'($urandom);
            n_chk++;
            if (o_Ready !== 1'b0) begin n_fail++; $display("FAIL blocked_ready: o_Ready=%b required 0", o_Ready); end
        end
    endtask

    task automatic send_block(input logic [127:0] blk, key, input logic dec, input int nb, input bit gap);
        int t;
        i_Key = key; i_fDec = dec;
        for (int i = 0; i < nb; i++) begin
            i_Valid = 1; i_Byte = blk[127-8*i -: 8];
            t = 0;
            while (o_Ready !== 1'b1 && t < 100) begin @(negedge Clk); t++; end
            if (o_Ready !== 1'b1) begin n_chk++; n_fail++; $display("FAIL ready_timeout: byte %0d o_Ready=%b required 1", i, o_Ready); end
            if (!gap && i > 0) begin
                n_chk++;
                if (t != 0) begin n_fail++; $display("FAIL in_throughput: byte %0d waited %0d required 0", i, t); end
            end
            @(negedge Clk);
            if (gap && i < nb - 1) begin i_Valid = 0; @(negedge Clk); end
        end
        i_Valid = 0;
        if (nb != 16) return;
        n_chk++;
        if (o_AesStart !== 1'b1 || o_Ready !== 1'b0) begin n_fail++; $display("FAIL launch_start: start=%b ready=%b required 1 0", o_AesStart, o_Ready); end
        n_chk++;
        if (o_AesData !== blk) begin n_fail++; $display("FAIL launch_data: %h required %h", o_AesData, blk); end
        n_chk++;
        if (o_AesKey !== key || o_AesDec !== dec) begin n_fail++; $display("FAIL launch_key_mode: %h %b required %h %b", o_AesKey, o_AesDec, key, dec); end
        @(negedge Clk);
        n_chk++;
        if (o_AesStart !== 1'b0 || o_Busy !== 1'b1 || o_Ready !== 1'b0) begin
            n_fail++; $display("FAIL wait_entry: start=%b busy=%b ready=%b required 0 1 0", o_AesStart, o_Busy, o_Ready);
        end
    endtask

    task automatic recv_block(input logic [127:0] exp, input int stall, input bit rnd, input bit junk);
        int t, ns;
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = exp[127-8*i -: 8];
            i_Ready = 0;
            t = 0;
            while (o_Valid !== 1'b1 && t < 200) begin offer_junk(junk); @(negedge Clk); t++; end
            if (o_Valid !== 1'b1) begin n_chk++; n_fail++; $display("FAIL valid_timeout: byte %0d o_Valid=%b required 1", i, o_Valid); end
            if (!rnd && stall == 0 && i > 0) begin
                n_chk++;
                if (t != 0) begin n_fail++; $display("FAIL out_throughput: byte %0d waited %0d required 0", i, t); end
            end
            n_chk++;
            if (o_Byte !== b) begin n_fail++; $display("FAIL out_byte: byte %0d got %h required %h", i, o_Byte, b); end
            ns = (i == 0 ? stall : 0) + (rnd ? int'($urandom_range(0, 2)) : 0);
            repeat (ns) begin
                i_Ready = 0; offer_junk(junk);
                @(negedge Clk);
                n_chk++;
                if (o_Valid !== 1'b1 || o_Byte !== b) begin n_fail++; $display("FAIL out_hold: byte %0d valid=%b byte=%h required 1 %h", i, o_Valid, o_Byte, b); end
            end
            i_Ready = 1; i_Valid = 0;
            if (i < 15) offer_junk(junk);
            @(negedge Clk);
        end
        i_Ready = 0; i_Valid = 0;
        n_chk++;
        if (o_Valid !== 1'b0 || o_Busy !== 1'b0) begin n_fail++; $display("FAIL unload_end: valid=%b busy=%b required 0 0", o_Valid, o_Busy); end
    endtask

    task automatic run_block(input logic [127:0] blk, key, input logic dec, input bit gap, input int stall, input bit rnd, input bit junk);
        int n0;
        n0 = n_start;
        send_block(blk, key, dec, 16, gap);
        recv_block(core_fn(blk, key, dec), stall, rnd, junk);
        n_chk++;
        if (n_start != n0 + 1) begin n_fail++; $display("FAIL start_count: %0d pulses required 1", n_start - n0); end
    endtask

    task automatic check_idle(input string tag);
        n_chk++;
        if ({o_Ready, o_Valid, o_AesStart, o_Busy, o_Err, o_AesDec} !== 6'b0 || o_AesData !== '0 || o_AesKey !== '0 || o_Byte !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: rdy=%b vld=%b st=%b busy=%b err=%b dec=%b data=%h key=%h byte=%h required all 0",
                     tag, o_Ready, o_Valid, o_AesStart, o_Busy, o_Err, o_AesDec, o_AesData, o_AesKey, o_Byte);
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge Clk); #2 Rst = 0;
        @(negedge Clk);
        check_idle(tag);
        @(posedge Clk); #2 Rst = 1;
        @(negedge Clk); @(negedge Clk);
    endtask

    task automatic test_reset();
        @(negedge Clk);
        check_idle("reset_values");
        @(posedge Clk); #2 Rst = 1;
        @(negedge Clk);
        n_chk++;
        if (o_Ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: %b required 0", o_Ready); end
        @(negedge Clk);
        n_chk++;
        if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: %b required 1", o_Ready); end
    endtask

    task automatic test_encrypt();    core_lat = 3; run_block(PT, K, 0, 0, 0, 0, 0); endtask
    task automatic test_decrypt();    core_lat = 0; run_block(CT, K, 1, 0, 0, 0, 0); endtask
    task automatic test_backpressure(); core_lat = 1; run_block(PT, K, 0, 0, 5, 0, 0); endtask
    task automatic test_gapped();     core_lat = 4; run_block(PT, K, 0, 1, 0, 0, 1); endtask

    task automatic test_back_to_back();
        core_lat = 0;
        for (int i = 0; i < 2; i++) run_block({4{$urandom}}, {4{$urandom}}, 1'($urandom), 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            core_lat = $urandom_range(0, 6);
            run_block({4{$urandom}}, {4{$urandom}}, 1'($urandom), 1'($urandom), 0, 1, 1'($urandom));
        end
    endtask

    task automatic test_late_done();
        inject = 1;
        repeat (3) begin
            @(negedge Clk);
            n_chk++;
            if (o_Valid !== 1'b0 || o_Busy !== 1'b0) begin n_fail++; $display("FAIL late_done: valid=%b busy=%b required 0 0", o_Valid, o_Busy); end
        end
        core_lat = 2;
        run_block(PT, K, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        send_block(CT, ~K, 1, 7, 0);
        do_reset("reset_mid_load");
        run_block(PT, K, 0, 0, 0, 0, 0);
        core_lat = 30;
        send_block(PT, K, 0, 16, 0);
        do_reset("reset_mid_wait");
        repeat (35) begin
            @(negedge Clk);
            n_chk++;
            if (o_Valid !== 1'b0 || o_Busy !== 1'b0) begin n_fail++; $display("FAIL abandoned_op: valid=%b busy=%b required 0 0", o_Valid, o_Busy); end
        end
        core_lat = 1;
        run_block(PT, K, 0, 0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        core_en = 0;
        send_block(PT, K, 0, 16, 0);
`ifdef AES_STREAM_TIMEOUT_EN
        repeat (TO - 1) @(negedge Clk);
        n_chk++;
        if (o_Err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: o_Err=%b required 0", o_Err); end
        @(negedge Clk);
        n_chk++;
        if (o_Err !== 1'b1 || o_Ready !== 1'b0 || o_Valid !== 1'b0 || o_Busy !== 1'b1) begin
            n_fail++; $display("FAIL timeout_err: err=%b rdy=%b vld=%b busy=%b required 1 0 0 1", o_Err, o_Ready, o_Valid, o_Busy);
        end
        i_Valid = 1;
        repeat (5) @(negedge Clk);
        n_chk++;
        if (o_Err !== 1'b1 || o_Ready !== 1'b0) begin n_fail++; $display("FAIL err_sticky: err=%b rdy=%b required 1 0", o_Err, o_Ready); end
`else
        repeat (3 * TO) @(negedge Clk);
        n_chk++;
        if (o_Err !== 1'b0 || o_Busy !== 1'b1 || o_Valid !== 1'b0) begin
            n_fail++; $display("FAIL no_watchdog: err=%b busy=%b vld=%b required 0 1 0", o_Err, o_Busy, o_Valid);
        end
`endif
        i_Valid = 0;
        do_reset("reset_after_timeout");
        core_en = 1;
        run_block(CT, K, 1, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_gapped();
        test_back_to_back();
        test_late_done();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
